// File: rtl/reg_file_seq_pkg.sv
// Shared types for the register-file command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_file_seq_pkg;

    // Byte width of the register file data path.
    localparam int DW = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    // Command opcode as carried on cmd_op.
    typedef enum logic {
        OP_DUMP = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

endpackage : reg_file_seq_pkg

// File: rtl/reg_file_seq.sv
// Command-driven bulk dump/load initiator for an 8-bit register file.
// Latency: accept -> first out byte visible after 2 edges; LOAD writes land on each in handshake edge.
// Backpressure: out_ready low holds the output byte and stalls; in_valid gaps stall LOAD.
module reg_file_seq
    import reg_file_seq_pkg::*;
#(
    parameter int pw = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [pw:0]   cmd_base,
    input  logic [pw:0]   cmd_count,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [pw:0]   rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic [pw:0]   rf_wr_addr,
    output logic          rf_wr_en,
    output logic [DW-1:0] rf_wr_data
);

    // Number of registers, expressed in the count width so clamping compares cleanly.
    localparam logic [pw:0] NREG     = {1'b1, {pw{1'b0}}};
    localparam logic [pw:0] REM_ZERO = '0;
    localparam logic [pw:0] REM_ONE  = {{pw{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [pw-1:0]   ptr_q, ptr_d;
    logic [pw:0]     rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    logic [pw:0]     count_clamped;
    logic            slot_free;
    logic            wr_hs;

    // Oversized counts collapse to a full sweep of the file.
    assign count_clamped = (cmd_count > NREG) ? NREG : cmd_count;

    // The output holding register can take a new byte when empty or being drained this cycle.
    assign slot_free = !out_valid_q || out_ready;

    // Next-state, pointer/counter and handshake decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        wr_hs       = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ptr_d = cmd_base[pw-1:0];
                    rem_d = count_clamped;
                    if (count_clamped == REM_ZERO) begin
                        state_d = DONE;
                    end else if (op_t'(cmd_op) == OP_LOAD) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DUMP;
                    end
                end
            end

            DUMP: begin
                if (slot_free) begin
                    if (rem_q != REM_ZERO) begin
                        out_data_d  = rf_rd_data;
                        out_valid_d = 1'b1;
                        ptr_d       = ptr_q + 1'b1;
                        rem_d       = rem_q - 1'b1;
                    end else begin
                        // Last byte has been taken; retire the slot and finish.
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end
                end
            end

            LOAD: begin
                in_ready = (rem_q != REM_ZERO);
                if (rem_q == REM_ZERO) begin
                    state_d = DONE;
                end else if (in_valid) begin
                    wr_hs = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    // Leave on the final write so LOAD costs no idle cycle.
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output holding register; reset also discards any half-sent byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Both file ports point at the current register; the MSB selects nothing here.
    assign rf_rd_addr = {1'b0, ptr_q};
    assign rf_wr_addr = {1'b0, ptr_q};
    assign rf_wr_data = in_data;
    // A write coinciding with reset is dropped so the file never sees a half-aborted LOAD.
    assign rf_wr_en   = wr_hs && rst_n;

endmodule : reg_file_seq

// File: tb/tb_reg_file_seq.sv
// Self-checking bench for reg_file_seq with a behavioural register file and scoreboard.
// Latency: checks DUMP first-byte timing, back-to-back bytes and done placement.
// Backpressure: drives out_ready in steady, 1-0-0 and random patterns; random in_valid gaps.
module tb_reg_file_seq;

    localparam int PW = 2;
    localparam int NR = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic [PW:0]  cmd_base;
    logic [PW:0]  cmd_count;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         busy;
    logic         done;
    logic [PW:0]  rf_rd_addr;
    logic [7:0]   rf_rd_data;
    logic [PW:0]  rf_wr_addr;
    logic         rf_wr_en;
    logic [7:0]   rf_wr_data;

    // Environment register file: what the parent would wire to the rf_* ports.
    logic [7:0] rf_env [8] = '{8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h75};

    // Reference contents of the file as dictated by completed commands.
    logic [7:0] model [NR];
    logic [7:0] sb [$];
    logic [7:0] load_bytes [$];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int exp_hs = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int rmode = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = rf_env[rf_rd_addr];

    always @(posedge clk) begin
        if (rf_wr_en) rf_env[rf_wr_addr] <= rf_wr_data;
    end

    reg_file_seq #(.pw(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_base   (cmd_base),
        .cmd_count  (cmd_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_data (rf_wr_data)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int clampc(input int c);
        return (c > NR) ? NR : c;
    endfunction

    // Offer a command and return in cycle E+1 (just after the accept edge).
    task automatic issue(input bit op, input int base, input int cnt);
        int guard;
        bit ok;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base[PW:0];
        cmd_count = cnt[PW:0];
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 50) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            guard++;
        end
        chk("cmd_accept_timeout", int'(ok), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int guard;
        bit seen;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < limit) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            guard++;
        end
        chk("done_timeout", int'(seen), 1);
    endtask

    task automatic do_dump(input int base, input int cnt, input int m);
        int n;
        rmode = m;
        n = clampc(cnt);
        for (int i = 0; i < n; i++) sb.push_back(model[(base + i) % NR]);
        exp_hs += n;
        exp_done++;
        issue(1'b0, base, cnt);
        @(negedge clk);
        if (n == 0) begin
            chk("dump0_done_next", int'(done), 1);
            chk("dump0_no_outvalid", int'(out_valid), 0);
            chk("dump0_no_wr", int'(rf_wr_en), 0);
            return;
        end
        chk("dump_busy", int'(busy), 1);
        chk("dump_lat_e1", int'(out_valid), 0);
        @(negedge clk);
        chk("dump_lat_e2", int'(out_valid), 1);
        if (m == 0) begin
            for (int i = 1; i < n; i++) begin
                @(negedge clk);
                chk("dump_consecutive", int'(out_valid), 1);
            end
            @(negedge clk);
            chk("dump_done_after_last", int'(done), 1);
            chk("dump_outvalid_cleared", int'(out_valid), 0);
        end else begin
            wait_done(200);
        end
    endtask

    // rst_at: index of the handshake during which reset is asserted, or -1.
    task automatic do_load(input int base, input int cnt, input int rst_at);
        int n;
        int idx;
        int guard;
        bit first;
        bit hit;
        n = clampc(cnt);
        issue(1'b1, base, cnt);
        if (n == 0) begin
            exp_done++;
            @(negedge clk);
            chk("load0_done_next", int'(done), 1);
            chk("load0_no_wr", int'(rf_wr_en), 0);
            chk("load0_no_inready", int'(in_ready), 0);
            return;
        end
        idx = 0;
        guard = 0;
        first = 1'b1;
        hit = 1'b0;
        while (idx < n && !hit && guard < 500) begin
            in_valid = first || ($urandom_range(0, 3) != 0);
            in_data  = load_bytes[idx];
            @(negedge clk);
            if (first) begin
                chk("load_first_inready", int'(in_ready), 1);
                first = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (idx == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("reset_drops_write", int'(rf_wr_en), 0);
                    hit = 1'b1;
                end else begin
                    chk("load_wr_en", int'(rf_wr_en), 1);
                    chk("load_wr_addr", int'(rf_wr_addr), (base + idx) % NR);
                    chk("load_wr_data", int'(rf_wr_data), int'(load_bytes[idx]));
                    model[(base + idx) % NR] = load_bytes[idx];
                end
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("load_stall_timeout", int'(idx == n || hit), 1);
        if (hit) begin
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_busy", int'(busy), 0);
            chk("rst_cmd_ready", int'(cmd_ready), 1);
            chk("rst_done", int'(done), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            return;
        end
        exp_done++;
        wait_done(50);
        for (int r = 0; r < NR; r++) chk("load_file_contents", int'(rf_env[r]), int'(model[r]));
    endtask

    initial begin
        logic [7:0] prev_data;
        bit prev_stall;
        bit prev_done;

        for (int r = 0; r < NR; r++) model[r] = rf_env[r];
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_base = '0;
        cmd_count = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        prev_data = '0;
        prev_stall = 1'b0;
        prev_done = 1'b0;

        // out_ready driver.
        fork
            forever begin
                int ph;
                @(posedge clk); #1;
                ph = cyc % 3;
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = (ph == 0);
                    default: out_ready = ($urandom_range(0, 1) == 1);
                endcase
            end
        join_none

        // Monitor: scoreboard pops, hold-stability and done pulse width.
        fork
            forever begin
                @(negedge clk);
                if (prev_stall) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), int'(prev_data));
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (sb.size() == 0) begin
                        chk("unexpected_out_byte", 1, 0);
                    end else begin
                        chk("out_data", int'(out_data), int'(sb.pop_front()));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_single_cycle", int'(prev_done), 0);
                end
                prev_done  = done;
                prev_stall = out_valid && !out_ready && rst_n;
                prev_data  = out_data;
            end
        join_none

        // Watchdog.
        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (cyc > 50000) begin
                    failures++;
                    $display("FAIL watchdog cycles=%0d limit=50000", cyc);
                    $fatal(1, "watchdog expired");
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_wr_en", int'(rf_wr_en), 0);
        chk("reset_rd_addr", int'(rf_rd_addr), 0);

        // LOAD then DUMP.
        load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(0, 4, -1);
        do_dump(0, 4, 0);
        chk("done_pulses_two", done_cnt, 2);

        // Wrap-around.
        do_dump(3, 3, 0);

        // Backpressure.
        do_dump(0, 4, 1);

        // Zero counts.
        do_dump(2, 0, 0);
        do_load(1, 0, -1);

        // Clamped counts; base MSB set and ignored.
        load_bytes = '{};
        for (int i = 0; i < 8; i++) load_bytes.push_back(8'($urandom));
        do_load(5, 7, -1);
        do_dump(1, 7, 2);

        // Reset during the second LOAD handshake.
        load_bytes = '{8'h55, 8'hAA, 8'hBB, 8'hCC};
        do_load(0, 4, 1);
        do_dump(0, 4, 0);

        // Random command mix.
        for (int k = 0; k < 16; k++) begin
            int b;
            int c;
            b = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                load_bytes = '{};
                for (int i = 0; i < 8; i++) load_bytes.push_back(8'($urandom));
                do_load(b, c, -1);
            end else begin
                do_dump(b, c, $urandom_range(0, 2));
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("total_out_handshakes", hs_cnt, exp_hs);
        chk("total_done_pulses", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file_seq

// File: doc/reg_file_seq.md
# reg_file_seq

Command-driven initiator for the 8-bit register file's address/data ports. It bulk-dumps a run of registers onto a valid/ready byte stream, or bulk-loads a run of registers from a valid/ready byte stream. It sits beside the register file in the parent. The parent muxes this block's write port onto the file while `busy` is high, so the block is the sole writer during an operation.

## Interface
- `pw`, 2: register pointer parameter. 2**pw registers; address ports are pw+1 bits wide. The address MSB is always driven 0.
- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  synchronous reset, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when valid&&ready.
- `cmd_op`  in  1  0 = DUMP, 1 = LOAD.
- `cmd_base`  in  pw+1  first register; the MSB is ignored.
- `cmd_count`  in  pw+1  number of registers; values > 2**pw clamp to 2**pw.
- `in_valid`  in  1  LOAD data valid.
- `in_ready`  out  1  LOAD data accepted when valid&&ready.
- `in_data`  in  8  LOAD byte.
- `out_valid`  out  1  DUMP byte valid.
- `out_ready`  in  1  DUMP byte consumed when valid&&ready.
- `out_data`  out  8  DUMP byte.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse at the end of each command.
- `rf_rd_addr`  out  pw+1  register file read address.
- `rf_rd_data`  in  8  register file read data; combinational from `rf_rd_addr`.
- `rf_wr_addr`  out  pw+1  register file write address.
- `rf_wr_en`  out  1  register file write enable.
- `rf_wr_data`  out  8  register file write data.

## Operation
- **State machine:** IDLE, DUMP, LOAD, DONE.
- **Pointer and counter:** `ptr` is pw bits and wraps modulo 2**pw (base 3, count 3, pw=2 → regs 3,0,1). `rem` is pw+1 bits and holds the remaining transfers.
- **IDLE:**
  - `cmd_ready`=1.
  - On accept: `ptr`←`cmd_base`[pw-1:0] and `rem`←clamped count.
  - Next state is DUMP or LOAD per `cmd_op`.
  - If the clamped count is 0, go straight to DONE; nothing is transferred.
- **DUMP:**
  - `rf_rd_addr`={0,`ptr`}.
  - When `rem`≠0 and the output slot is free (!`out_valid` || `out_ready`): `out_data`←`rf_rd_data`, `out_valid`←1, `ptr`++, `rem`--.
  - When `rem`=0 and the slot is free: `out_valid`←0 and go to DONE.
  - `out_data` is held stable while `out_valid` is high and `out_ready` is low.
- **LOAD:**
  - `in_ready`=(`rem`≠0).
  - On an in handshake, combinationally: `rf_wr_en`=1, `rf_wr_addr`={0,`ptr`}, `rf_wr_data`=`in_data`. Registered: `ptr`++, `rem`--.
  - When `rem`=0, go to DONE.
- **DONE:** `done`=1 for one cycle, `cmd_ready`=0, then IDLE.
- **Quiet defaults:** `rf_wr_en`=0 outside LOAD handshakes; `rf_rd_addr`={0,`ptr`} in all states; `in_ready`=0 outside LOAD.
- **Reset, mid-operation included:**
  - State←IDLE; `out_valid`, `done`, `ptr`, `rem`, `out_data`←0.
  - `rf_wr_en` is forced 0 in any cycle where `rst_n`=0, so a pending LOAD write is dropped.
  - A partially dumped byte is discarded.
- **Command overlap:** commands are never accepted while `busy`; `cmd_valid` in busy states is ignored (held by the sender).

## Timing
- **Reset values:** `cmd_ready`=1 and `busy`=0 in the first cycle after reset; all other outputs 0.
- **DUMP latency:**
  - Accept at edge E; DUMP state in cycle E+1.
  - First `out_valid` is visible after edge E+2.
  - With `out_ready` held high, one byte per cycle; `done` is in the cycle after the last byte handshake.
- **LOAD:**
  - First `in_ready` in cycle E+1.
  - Each write lands in the file at the edge that completes its handshake.
  - A DUMP issued right after a LOAD reads the new values.
- **Back-to-back:** minimum command period is count+2 cycles (accept, transfers, DONE).
- **Stalls:** backpressure on `out_ready` or gaps in `in_valid` stall the FSM with no loss or duplication.

## Structure
- **Package `reg_file_seq_pkg`:**
  - `state_t` enum {IDLE, DUMP, LOAD, DONE}.
  - `op_t` enum {OP_DUMP=1'b0, OP_LOAD=1'b1}.
  - Byte-width constant `DW`=8.
- **Sub-modules:** none; the FSM, pointer/counter and output holding register stay in one module. The parent instantiates the register file and wires the `rf_*` ports to it.

## Test plan
- **LOAD then DUMP:** reset, then LOAD base 0 count 4 with bytes 0x11,0x22,0x33,0x44, then DUMP base 0 count 4 with `out_ready`=1 → out 0x11,0x22,0x33,0x44 on consecutive cycles; first `out_valid` 2 cycles after accept; `done` pulses twice.
- **Wrap-around:** DUMP base 3 count 3 after the above → 0x44,0x11,0x22.
- **Backpressure:** DUMP count 4 with `out_ready` toggling 1,0,0,1,… → each byte held stable until consumed; exactly 4 handshakes; no duplicates.
- **Count edge cases:**
  - Count 0 → `done` the cycle after accept, no `rf_wr_en` and no `out_valid`.
  - Count 7 with pw=2 → clamped to 4 transfers.
- **Reset mid-LOAD:** assert `rst_n`=0 during the 2nd `in_data` handshake (0xAA to reg 1) → reg 1 is unchanged; `busy`=0 and `cmd_ready`=1 after reset; a following DUMP returns the old contents.
